jam_cost_arbiter: RTL and testbench

Round-robin arbiter that shares the single job-cost table port (W/J out, Cost in) among NREQ assignment-search engines. Each engine evaluates one permutation as a locked burst of worker/job reads. The arbiter serialises the bursts, drives W/J, and routes each returned Cost back to the engine that issued it. It sits between the engines and the top-level cost-table pins.

---
 rtl/jam_cost_arbiter_pkg.sv | 44 ++++
 rtl/jam_cost_arbiter_if.sv | 29 ++
 rtl/jam_cost_arbiter_rr_pick.sv | 28 ++
 rtl/jam_cost_arbiter.sv | 137 +++++++++++++
 tb/tb_jam_cost_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/jam_cost_arbiter_pkg.sv
// Shared types and constants for the cost-table arbiter.
// Also holds the round-robin pick helper used by the pick sub-module.
package jam_cost_arbiter_pkg;

  localparam int COST_W       = 7;
  localparam int IDX_W        = 3;
  localparam int MAXBURST_DEF = 8;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_e;

  // Rotate so that engine last+1 sits at position 0, take the lowest set bit,
  // then rotate the one-hot result back into engine numbering.
  function automatic logic [3:0] next_rr(input logic [3:0] valid,
                                         input logic [1:0] last,
                                         input int         n);
    logic [3:0] rot;
    logic [3:0] pri;
    logic [3:0] pick;
    logic [1:0] idx;
    rot  = '0;
    pri  = '0;
    pick = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < n) begin
        idx    = 2'((int'(last) + 1 + k) % n);
        rot[k] = valid[idx];
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (k < n && rot[k] && pri == '0) pri[k] = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      if (k < n) begin
        idx = 2'((int'(last) + 1 + k) % n);
        if (pri[k]) pick[idx] = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/jam_cost_arbiter_if.sv
// Engine/cost-table bus shared by the arbiter and the engines plus table.
// The slave modport is the arbiter's view; master is the engines' and table's view.
interface jam_cost_arbiter_if #(
  parameter int NREQ = 2,
  parameter int CW   = 7
);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_last;
  logic [3*NREQ-1:0] req_w;
  logic [3*NREQ-1:0] req_j;
  logic [NREQ-1:0]   req_ready;
  logic [2:0]        W;
  logic [2:0]        J;
  logic [CW-1:0]     Cost;
  logic [NREQ-1:0]   rsp_valid;
  logic [CW-1:0]     rsp_cost;

  modport slave (
    input  req_valid, req_last, req_w, req_j, Cost,
    output req_ready, W, J, rsp_valid, rsp_cost
  );

  modport master (
    output req_valid, req_last, req_w, req_j, Cost,
    input  req_ready, W, J, rsp_valid, rsp_cost
  );

endinterface

// File: rtl/jam_cost_arbiter_rr_pick.sv
// Combinational round-robin pick: one-hot winner plus its index,
// searching upward from the engine after lastOwner.
module jam_cost_arbiter_rr_pick
  import jam_cost_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [1:0]      lastOwner_i,
  output logic [NREQ-1:0] pick_o,
  output logic [1:0]      pickIdx_o
);

  logic [3:0] validW;
  logic [3:0] pickW;

  always_comb begin
    validW             = '0;
    validW[NREQ-1:0]   = valid_i;
    pickW              = next_rr(validW, lastOwner_i, NREQ);
    pick_o             = pickW[NREQ-1:0];
    pickIdx_o          = '0;
    for (int i = 0; i < 4; i++) begin
      if (pickW[i]) pickIdx_o = 2'(i);
    end
  end

endmodule

// File: rtl/jam_cost_arbiter.sv
// Round-robin arbiter sharing the job-cost table port among NREQ engines,
// granting locked bursts and routing each returned Cost to its issuer.
module jam_cost_arbiter
  import jam_cost_arbiter_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int MAXBURST = MAXBURST_DEF,
  parameter int CW       = COST_W
) (
  input logic               CLK,
  input logic               RST,
  jam_cost_arbiter_if.slave bus
);

  localparam logic [4:0] MaxBurst5 = 5'(MAXBURST);
  localparam logic [1:0] LastReset = 2'(NREQ - 1);

  arb_state_e            state_q, state_d;
  logic [1:0]            owner_q, owner_d;
  logic [1:0]            lastOwner_q, lastOwner_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [NREQ-1:0]       tag_q, tag_d;
  logic [NREQ-1:0]       rspValid_q, rspValid_d;
  logic [IDX_W-1:0]      w_q, w_d;
  logic [IDX_W-1:0]      j_q, j_d;
  logic [CW-1:0]         rspCost_q, rspCost_d;

  logic [NREQ-1:0]       pickOh;
  logic [NREQ-1:0]       ownerOh;
  logic [NREQ-1:0]       readyOh;
  logic [1:0]            pickIdx;
  logic [1:0]            selIdx;
  logic [IDX_W-1:0]      selW;
  logic [IDX_W-1:0]      selJ;
  logic                  selLast;
  logic                  accept;
  logic                  endBurst;

  jam_cost_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
    .valid_i     (bus.req_valid),
    .lastOwner_i (lastOwner_q),
    .pick_o      (pickOh),
    .pickIdx_o   (pickIdx)
  );

  // In IDLE the pick is live; in BUSY the owner keeps the grant even while idle.
  always_comb begin
    ownerOh = '0;
    selW    = '0;
    selJ    = '0;
    selLast = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      ownerOh[i] = (owner_q == 2'(i));
    end
    readyOh = (state_q == IDLE) ? pickOh : ownerOh;
    selIdx  = (state_q == IDLE) ? pickIdx : owner_q;
    for (int i = 0; i < NREQ; i++) begin
      if (selIdx == 2'(i)) begin
        selW    = bus.req_w[3*i +: 3];
        selJ    = bus.req_j[3*i +: 3];
        selLast = bus.req_last[i];
      end
    end
    accept   = |(bus.req_valid & readyOh);
    endBurst = selLast || (({1'b0, cnt_q} + 5'd1) == MaxBurst5);
  end

  // cnt is 0 in IDLE, so the same endBurst test covers MAXBURST==1 single-beat grants.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lastOwner_d = lastOwner_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (endBurst) begin
            lastOwner_d = pickIdx;
          end else begin
            state_d = BUSY;
            owner_d = pickIdx;
            cnt_d   = 4'd1;
          end
        end
      end
      BUSY: begin
        if (accept) begin
          if (endBurst) begin
            state_d     = IDLE;
            lastOwner_d = owner_q;
            cnt_d       = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    tag_d      = accept ? readyOh : '0;
    w_d        = accept ? selW : w_q;
    j_d        = accept ? selJ : j_q;
    rspValid_d = tag_q;
    rspCost_d  = (|tag_q) ? bus.Cost : rspCost_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      lastOwner_q <= LastReset;
      cnt_q       <= '0;
      tag_q       <= '0;
      rspValid_q  <= '0;
      w_q         <= '0;
      j_q         <= '0;
      rspCost_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lastOwner_q <= lastOwner_d;
      cnt_q       <= cnt_d;
      tag_q       <= tag_d;
      rspValid_q  <= rspValid_d;
      w_q         <= w_d;
      j_q         <= j_d;
      rspCost_q   <= rspCost_d;
    end
  end

  assign bus.req_ready = readyOh;
  assign bus.W         = w_q;
  assign bus.J         = j_q;
  assign bus.rsp_valid = rspValid_q;
  assign bus.rsp_cost  = rspCost_q;

endmodule

// File: tb/tb_jam_cost_arbiter.sv
// Directed bench for jam_cost_arbiter: a 2-engine instance for bursts, contention,
// gaps, forced release and reset, plus a 4-engine instance for rotation order.
module tb_jam_cost_arbiter;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checkCount = 0;
  int   passCount  = 0;

  always #5 CLK = ~CLK;

  jam_cost_arbiter_if #(.NREQ(2), .CW(7)) if2 ();
  jam_cost_arbiter_if #(.NREQ(4), .CW(7)) if4 ();

  // Cost table model: cost = 10 * worker, looked up from the registered W.
  assign if2.Cost = 7'(if2.W) * 7'd10;
  assign if4.Cost = 7'(if4.W) * 7'd10;

  jam_cost_arbiter #(.NREQ(2), .MAXBURST(8), .CW(7)) dut2 (
    .CLK (CLK),
    .RST (RST),
    .bus (if2.slave)
  );

  jam_cost_arbiter #(.NREQ(4), .MAXBURST(8), .CW(7)) dut4 (
    .CLK (CLK),
    .RST (RST),
    .bus (if4.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] last,
                               input logic [2:0] w0, input logic [2:0] j0,
                               input logic [2:0] w1, input logic [2:0] j1);
    if2.req_valid = valid;
    if2.req_last  = last;
    if2.req_w     = {w1, w0};
    if2.req_j     = {j1, j0};
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  expReady;
    logic [1:0]  prevReady;
    logic [10:0] gapPat;
    int          b0;
    int          b1;

    applyStimulus(2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 3'd0);
    if4.req_valid = '0;
    if4.req_last  = '0;
    if4.req_w     = '0;
    if4.req_j     = '0;

    // Reset state
    tick();
    checkOutput("rstW", 32'(if2.W), 0);
    checkOutput("rstJ", 32'(if2.J), 0);
    checkOutput("rstRspValid", 32'(if2.rsp_valid), 0);
    checkOutput("rstRspCost", 32'(if2.rsp_cost), 0);
    checkOutput("rstReady", 32'(if2.req_ready), 0);
    checkOutput("rstReady4", 32'(if4.req_ready), 0);
    RST = 1'b0;

    // Single engine burst of 8
    for (int b = 0; b < 8; b++) begin
      applyStimulus(2'b01, {1'b0, b == 7}, 3'(b), 3'(7 - b), 3'd0, 3'd0);
      #1;
      checkOutput("burstReady", 32'(if2.req_ready), 1);
      tick();
      checkOutput("burstW", 32'(if2.W), 32'(b));
      checkOutput("burstJ", 32'(if2.J), 32'(7 - b));
      checkOutput("burstRspValid", 32'(if2.rsp_valid), (b == 0) ? 0 : 1);
      if (b > 0) checkOutput("burstRspCost", 32'(if2.rsp_cost), 32'(10 * (b - 1)));
    end
    applyStimulus(2'b10, 2'b00, 3'd0, 3'd0, 3'd0, 3'd0);
    #1;
    checkOutput("burstIdlePick", 32'(if2.req_ready), 2);
    applyStimulus(2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 3'd0);
    tick();
    checkOutput("burstLastRsp", 32'(if2.rsp_valid), 1);
    checkOutput("burstLastCost", 32'(if2.rsp_cost), 70);
    tick();
    checkOutput("burstDrained", 32'(if2.rsp_valid), 0);

    // Contention: both engines stream 8-beat bursts from reset
    RST = 1'b1;
    tick();
    RST = 1'b0;
    b0 = 0;
    b1 = 0;
    prevReady = 2'b00;
    for (int c = 0; c < 32; c++) begin
      applyStimulus(2'b11, {b1 == 7, b0 == 7}, 3'(b0), 3'd0, 3'(b1), 3'd1);
      #1;
      expReady = (((c / 8) % 2) == 0) ? 2'b01 : 2'b10;
      checkOutput("contReady", 32'(if2.req_ready), 32'(expReady));
      if (if2.req_ready[0]) b0 = (b0 + 1) % 8;
      if (if2.req_ready[1]) b1 = (b1 + 1) % 8;
      tick();
      checkOutput("contRspValid", 32'(if2.rsp_valid), 32'(prevReady));
      prevReady = expReady;
    end

    // Owner gap: engine 0 idles 3 cycles mid-burst, never sends last
    gapPat = 11'b11111100011;
    b0 = 0;
    for (int c = 0; c < 11; c++) begin
      applyStimulus({1'b1, gapPat[c]}, 2'b00, 3'(b0), 3'd0, 3'd0, 3'd1);
      #1;
      checkOutput("gapReady", 32'(if2.req_ready), 1);
      if (gapPat[c]) b0++;
      tick();
    end

    // Forced release: engine 1 never sends last
    for (int c = 0; c < 8; c++) begin
      applyStimulus(2'b11, 2'b00, 3'd0, 3'd0, 3'(c), 3'd1);
      #1;
      checkOutput("forceReady", 32'(if2.req_ready), 2);
      tick();
    end
    applyStimulus(2'b11, 2'b00, 3'd5, 3'd3, 3'd0, 3'd1);
    #1;
    checkOutput("forceHandover", 32'(if2.req_ready), 1);
    tick();
    checkOutput("preRstW", 32'(if2.W), 5);
    checkOutput("preRstJ", 32'(if2.J), 3);

    // Reset one cycle after an accept
    RST = 1'b1;
    #1;
    checkOutput("midRstRspValid", 32'(if2.rsp_valid), 0);
    checkOutput("midRstW", 32'(if2.W), 0);
    checkOutput("midRstJ", 32'(if2.J), 0);
    checkOutput("midRstRspCost", 32'(if2.rsp_cost), 0);
    checkOutput("midRstReady", 32'(if2.req_ready), 1);
    tick();
    checkOutput("midRstHeldRsp", 32'(if2.rsp_valid), 0);
    RST = 1'b0;
    #1;
    checkOutput("postRstReady", 32'(if2.req_ready), 1);
    tick();
    applyStimulus(2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 3'd0);
    checkOutput("postRstRspEarly", 32'(if2.rsp_valid), 0);
    tick();
    checkOutput("postRstRsp", 32'(if2.rsp_valid), 1);
    checkOutput("postRstCost", 32'(if2.rsp_cost), 50);

    // NREQ=4 rotation: make engine 1 last owner, then engines 1 and 3 contend
    if4.req_valid = 4'b0010;
    if4.req_last  = 4'b0010;
    if4.req_w     = {3'd0, 3'd0, 3'd2, 3'd0};
    #1;
    checkOutput("rot4Single", 32'(if4.req_ready), 2);
    tick();
    if4.req_valid = 4'b1010;
    if4.req_last  = 4'b1010;
    if4.req_w     = {3'd6, 3'd0, 3'd2, 3'd0};
    #1;
    checkOutput("rot4First", 32'(if4.req_ready), 8);
    tick();
    checkOutput("rot4W", 32'(if4.W), 6);
    checkOutput("rot4RspA", 32'(if4.rsp_valid), 2);
    #1;
    checkOutput("rot4Second", 32'(if4.req_ready), 2);
    tick();
    if4.req_valid = 4'b0000;
    checkOutput("rot4RspB", 32'(if4.rsp_valid), 8);
    checkOutput("rot4CostB", 32'(if4.rsp_cost), 60);
    tick();
    checkOutput("rot4RspC", 32'(if4.rsp_valid), 2);
    checkOutput("rot4CostC", 32'(if4.rsp_cost), 20);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
